udp_tx_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the ROLE's single UDP transmit path (Udp data stream plus Udp meta stream toward NRC) between two internal application requesters. It sits inside the Themisto ROLE between user kernels and the SHELL-facing soNRC_Udp_Data / soROLE_Nrc_Udp_Meta ports. Each granted packet is emitted as one meta word followed by its complete data burst, never interleaved.

---
 rtl/udp_tx_arb_pkg.sv | 21 ++
 rtl/udp_tx_arbiter_rr_picker2.sv | 15 +
 rtl/udp_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_arb_pkg.sv
// Shared types and defaults for the ROLE UDP transmit arbiter.
// Optional packet counters are built when UDP_TX_ARB_STATS_EN is defined.
package udp_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    META = 2'd1,
    DATA = 2'd2
  } arbState_t;

  localparam int DATA_W_DEF = 64;
  localparam int META_W_DEF = 64;
  localparam int STAT_W_DEF = 16;

  function automatic int keepW(input int w);
    return w / 8;
  endfunction

  localparam int KEEP_W_DEF = keepW(DATA_W_DEF);

endpackage

// File: rtl/udp_tx_arbiter_rr_picker2.sv
// Two-way round-robin selector: the pointer's requester wins if it asks,
// otherwise the other one. Purely combinational.
module rr_picker2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grantIdx,
  output logic       grantVld
);

  always_comb begin
    grantVld = |req;
    grantIdx = req[ptr] ? ptr : ~ptr;
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter: one meta word then the full data
// burst per grant. Define UDP_TX_ARB_STATS_EN to build packet counters.
module udp_tx_arbiter
  import udp_tx_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int META_W = META_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic                piSHL_156_25Clk,
  input  logic                piSHL_156_25Rst,
  input  logic                piMMIO_Ly7_En,
  input  logic [META_W-1:0]   siApp0_Meta_tdata,
  input  logic                siApp0_Meta_tvalid,
  output logic                siApp0_Meta_tready,
  input  logic [DATA_W-1:0]   siApp0_Data_tdata,
  input  logic [DATA_W/8-1:0] siApp0_Data_tkeep,
  input  logic                siApp0_Data_tlast,
  input  logic                siApp0_Data_tvalid,
  output logic                siApp0_Data_tready,
  input  logic [META_W-1:0]   siApp1_Meta_tdata,
  input  logic                siApp1_Meta_tvalid,
  output logic                siApp1_Meta_tready,
  input  logic [DATA_W-1:0]   siApp1_Data_tdata,
  input  logic [DATA_W/8-1:0] siApp1_Data_tkeep,
  input  logic                siApp1_Data_tlast,
  input  logic                siApp1_Data_tvalid,
  output logic                siApp1_Data_tready,
  output logic [META_W-1:0]   soROLE_Nrc_Udp_Meta_TDATA,
  output logic [7:0]          soROLE_Nrc_Udp_Meta_TKEEP,
  output logic                soROLE_Nrc_Udp_Meta_TLAST,
  output logic                soROLE_Nrc_Udp_Meta_TVALID,
  input  logic                soROLE_Nrc_Udp_Meta_TREADY,
  output logic [DATA_W-1:0]   soNRC_Udp_Data_tdata,
  output logic [DATA_W/8-1:0] soNRC_Udp_Data_tkeep,
  output logic                soNRC_Udp_Data_tlast,
  output logic                soNRC_Udp_Data_tvalid,
  input  logic                soNRC_Udp_Data_tready,
  output logic                poArb_Busy,
  output logic                poArb_Grant,
  output logic [STAT_W-1:0]   poStat_Pkt0,
  output logic [STAT_W-1:0]   poStat_Pkt1
);

  localparam int KEEP_W = keepW(DATA_W);

  arbState_t state, nextState;
  logic grantQ, grantNxt;
  logic ptrQ;
  logic pickIdx, pickVld;
  logic metaRdy, dataRdy, pktDone;

  logic [META_W-1:0] gMetaData;
  logic              gMetaVld;
  logic [DATA_W-1:0] gData;
  logic [KEEP_W-1:0] gKeep;
  logic              gLast, gDataVld;

  rr_picker2 uPicker (
    .req      ({siApp1_Meta_tvalid, siApp0_Meta_tvalid}),
    .ptr      (ptrQ),
    .grantIdx (pickIdx),
    .grantVld (pickVld)
  );

  assign gMetaData = grantQ ? siApp1_Meta_tdata  : siApp0_Meta_tdata;
  assign gMetaVld  = grantQ ? siApp1_Meta_tvalid : siApp0_Meta_tvalid;
  assign gData     = grantQ ? siApp1_Data_tdata  : siApp0_Data_tdata;
  assign gKeep     = grantQ ? siApp1_Data_tkeep  : siApp0_Data_tkeep;
  assign gLast     = grantQ ? siApp1_Data_tlast  : siApp0_Data_tlast;
  assign gDataVld  = grantQ ? siApp1_Data_tvalid : siApp0_Data_tvalid;

  assign pktDone = (state == DATA) & gDataVld
                 & soNRC_Udp_Data_tready & gLast;

  always_comb begin
    nextState = state;
    grantNxt  = grantQ;
    metaRdy   = 1'b0;
    dataRdy   = 1'b0;
    soROLE_Nrc_Udp_Meta_TDATA  = '0;
    soROLE_Nrc_Udp_Meta_TKEEP  = '0;
    soROLE_Nrc_Udp_Meta_TLAST  = 1'b0;
    soROLE_Nrc_Udp_Meta_TVALID = 1'b0;
    soNRC_Udp_Data_tdata  = '0;
    soNRC_Udp_Data_tkeep  = '0;
    soNRC_Udp_Data_tlast  = 1'b0;
    soNRC_Udp_Data_tvalid = 1'b0;
    unique case (state)
      IDLE: begin
        if (piMMIO_Ly7_En && pickVld) begin
          grantNxt  = pickIdx;
          nextState = META;
        end
      end
      META: begin
        soROLE_Nrc_Udp_Meta_TDATA  = gMetaData;
        soROLE_Nrc_Udp_Meta_TKEEP  = 8'hFF;
        soROLE_Nrc_Udp_Meta_TLAST  = 1'b1;
        soROLE_Nrc_Udp_Meta_TVALID = gMetaVld;
        metaRdy = soROLE_Nrc_Udp_Meta_TREADY;
        if (gMetaVld && soROLE_Nrc_Udp_Meta_TREADY)
          nextState = DATA;
      end
      DATA: begin
        soNRC_Udp_Data_tdata  = gData;
        soNRC_Udp_Data_tkeep  = gKeep;
        soNRC_Udp_Data_tlast  = gLast;
        soNRC_Udp_Data_tvalid = gDataVld;
        dataRdy = soNRC_Udp_Data_tready;
        if (pktDone)
          nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Only the granted requester ever sees a ready.
  assign siApp0_Meta_tready = metaRdy & ~grantQ;
  assign siApp1_Meta_tready = metaRdy &  grantQ;
  assign siApp0_Data_tready = dataRdy & ~grantQ;
  assign siApp1_Data_tready = dataRdy &  grantQ;

  always_ff @(posedge piSHL_156_25Clk) begin
    if (piSHL_156_25Rst) begin
      state  <= IDLE;
      grantQ <= 1'b0;
      ptrQ   <= 1'b0;
    end else begin
      state  <= nextState;
      grantQ <= grantNxt;
      if (pktDone)
        ptrQ <= ~grantQ;
    end
  end

  assign poArb_Busy  = (state != IDLE);
  assign poArb_Grant = grantQ;

`ifdef UDP_TX_ARB_STATS_EN
  logic [STAT_W-1:0] cnt0, cnt1;

  always_ff @(posedge piSHL_156_25Clk) begin
    if (piSHL_156_25Rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (pktDone) begin
      if (grantQ)
        cnt1 <= cnt1 + STAT_W'(1);
      else
        cnt0 <= cnt0 + STAT_W'(1);
    end
  end

  assign poStat_Pkt0 = cnt0;
  assign poStat_Pkt1 = cnt1;
`else
  assign poStat_Pkt0 = '0;
  assign poStat_Pkt1 = '0;
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed self-checking bench for udp_tx_arbiter (STAT_W = 4 so wrap is
// reachable); counter expectations follow UDP_TX_ARB_STATS_EN.
module tb_udp_tx_arbiter;

  localparam int DW = 64;
  localparam int MW = 64;
  localparam int SW = 4;
  localparam int KW = DW / 8;
`ifdef UDP_TX_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  always #5 clk = ~clk;

  logic [MW-1:0] a0MetaData = '0, a1MetaData = '0;
  logic a0MetaVld = 0, a1MetaVld = 0, a0MetaRdy, a1MetaRdy;
  logic [DW-1:0] a0Data = '0, a1Data = '0;
  logic [KW-1:0] a0Keep = '0, a1Keep = '0;
  logic a0Last = 0, a1Last = 0, a0DVld = 0, a1DVld = 0;
  logic a0DRdy, a1DRdy;
  logic [MW-1:0] mOutData;
  logic [7:0] mOutKeep;
  logic mOutLast, mOutVld;
  logic mOutRdy = 1'b1;
  logic [DW-1:0] dOutData;
  logic [KW-1:0] dOutKeep;
  logic dOutLast, dOutVld;
  logic dOutRdy = 1'b1;
  logic busy, grant;
  logic [SW-1:0] stat0, stat1;

  udp_tx_arbiter #(.DATA_W(DW), .META_W(MW), .STAT_W(SW)) dut (
    .piSHL_156_25Clk            (clk),
    .piSHL_156_25Rst            (rst),
    .piMMIO_Ly7_En              (en),
    .siApp0_Meta_tdata          (a0MetaData),
    .siApp0_Meta_tvalid         (a0MetaVld),
    .siApp0_Meta_tready         (a0MetaRdy),
    .siApp0_Data_tdata          (a0Data),
    .siApp0_Data_tkeep          (a0Keep),
    .siApp0_Data_tlast          (a0Last),
    .siApp0_Data_tvalid         (a0DVld),
    .siApp0_Data_tready         (a0DRdy),
    .siApp1_Meta_tdata          (a1MetaData),
    .siApp1_Meta_tvalid         (a1MetaVld),
    .siApp1_Meta_tready         (a1MetaRdy),
    .siApp1_Data_tdata          (a1Data),
    .siApp1_Data_tkeep          (a1Keep),
    .siApp1_Data_tlast          (a1Last),
    .siApp1_Data_tvalid         (a1DVld),
    .siApp1_Data_tready         (a1DRdy),
    .soROLE_Nrc_Udp_Meta_TDATA  (mOutData),
    .soROLE_Nrc_Udp_Meta_TKEEP  (mOutKeep),
    .soROLE_Nrc_Udp_Meta_TLAST  (mOutLast),
    .soROLE_Nrc_Udp_Meta_TVALID (mOutVld),
    .soROLE_Nrc_Udp_Meta_TREADY (mOutRdy),
    .soNRC_Udp_Data_tdata       (dOutData),
    .soNRC_Udp_Data_tkeep       (dOutKeep),
    .soNRC_Udp_Data_tlast       (dOutLast),
    .soNRC_Udp_Data_tvalid      (dOutVld),
    .soNRC_Udp_Data_tready      (dOutRdy),
    .poArb_Busy                 (busy),
    .poArb_Grant                (grant),
    .poStat_Pkt0                (stat0),
    .poStat_Pkt1                (stat1)
  );

  logic [MW-1:0] mQ0[$], mQ1[$], outMeta[$];
  beat_t dQ0[$], dQ1[$], outBeat[$];
  int outMetaCyc[$], outBeatCyc[$];
  int cyc = 0;
  bit readyToggle = 1'b0;
  int nChecks = 0;
  int nFails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Sources pop on handshake; sink records accepted words with their cycle.
  always begin : srcSink
    bit hm0, hm1, hd0, hd1;
    beat_t b;
    @(negedge clk);
    hm0 = a0MetaVld && a0MetaRdy;
    hm1 = a1MetaVld && a1MetaRdy;
    hd0 = a0DVld && a0DRdy;
    hd1 = a1DVld && a1DRdy;
    if (mOutVld && mOutRdy) begin
      outMeta.push_back(mOutData);
      outMetaCyc.push_back(cyc);
    end
    if (dOutVld && dOutRdy) begin
      b = {dOutData, dOutKeep, dOutLast};
      outBeat.push_back(b);
      outBeatCyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (hm0 && mQ0.size() > 0) void'(mQ0.pop_front());
    if (hm1 && mQ1.size() > 0) void'(mQ1.pop_front());
    if (hd0 && dQ0.size() > 0) void'(dQ0.pop_front());
    if (hd1 && dQ1.size() > 0) void'(dQ1.pop_front());
    a0MetaVld = mQ0.size() > 0;
    a0MetaData = a0MetaVld ? mQ0[0] : '0;
    a1MetaVld = mQ1.size() > 0;
    a1MetaData = a1MetaVld ? mQ1[0] : '0;
    a0DVld = dQ0.size() > 0;
    b = a0DVld ? dQ0[0] : '0;
    {a0Data, a0Keep, a0Last} = b;
    a1DVld = dQ1.size() > 0;
    b = a1DVld ? dQ1[0] : '0;
    {a1Data, a1Keep, a1Last} = b;
    if (readyToggle) dOutRdy = ~dOutRdy;
  end

  function automatic logic [DW-1:0] beatWord(input int app, input int pkt,
                                             input int bi);
    return {8'hD0 + 8'(app), 8'(pkt), 40'h0, 8'(bi)};
  endfunction

  function automatic logic [MW-1:0] metaWord(input int app, input int pkt);
    return {8'hE0 + 8'(app), 8'(pkt), 48'h5A5A_0000_C3C3};
  endfunction

  task automatic pushPkt(input int app, input logic [MW-1:0] meta,
                         input int pkt, input int nb,
                         input logic [KW-1:0] lastKeep, input bit withMeta);
    beat_t x;
    for (int i = 0; i < nb; i++) begin
      x.d = beatWord(app, pkt, i);
      x.k = (i == nb - 1) ? lastKeep : 8'hFF;
      x.l = (i == nb - 1);
      if (app == 0) dQ0.push_back(x);
      else dQ1.push_back(x);
    end
    if (withMeta) begin
      if (app == 0) mQ0.push_back(meta);
      else mQ1.push_back(meta);
    end
  endtask

  task automatic waitBeats(input int n);
    for (int i = 0; i < 400 && outBeat.size() < n; i++) begin
      @(negedge clk);
      #2;
    end
    repeat (2) @(negedge clk);
    #2;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    readyToggle = 1'b0;
    repeat (2) @(negedge clk);
    mQ0.delete(); mQ1.delete(); dQ0.delete(); dQ1.delete();
    dOutRdy = 1'b1;
    @(negedge clk);
    outMeta.delete(); outBeat.delete();
    outMetaCyc.delete(); outBeatCyc.delete();
    rst = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    logic [15:0] got, exp;
    doReset();
    got = {mOutVld, dOutVld, busy, grant, a0MetaRdy, a1MetaRdy,
           a0DRdy, a1DRdy, mOutLast, dOutLast, 6'(mOutKeep == 0)};
    exp = 16'h0001;
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL reset_ctl: got %h expected %h", got, exp);
    end
    nChecks++;
    if ({stat0, stat1} !== '0) begin
      nFails++;
      $display("FAIL reset_stats: got %h %h expected 0 0", stat0, stat1);
    end
    nChecks++;
    if ({mOutData, dOutData} !== '0) begin
      nFails++;
      $display("FAIL reset_data: got %h %h expected 0", mOutData, dOutData);
    end
  endtask

  task automatic test_single();
    int t0;
    logic [KW-1:0] ek;
    doReset();
    pushPkt(0, 64'h0A0B_0C0D_1234_5678, 0, 3, 8'h0F, 1'b1);
    t0 = cyc + 1;
    waitBeats(3);
    nChecks++;
    if (outMeta.size() != 1 || outBeat.size() != 3) begin
      nFails++;
      $display("FAIL single_count: got %0d/%0d expected 1/3",
               outMeta.size(), outBeat.size());
    end else begin
      nChecks++;
      if (outMeta[0] !== 64'h0A0B_0C0D_1234_5678) begin
        nFails++;
        $display("FAIL single_meta: got %h expected 0a0b0c0d12345678",
                 outMeta[0]);
      end
      nChecks++;
      if (outMetaCyc[0] != t0 + 1) begin
        nFails++;
        $display("FAIL single_latency: got %0d expected %0d",
                 outMetaCyc[0], t0 + 1);
      end
      for (int i = 0; i < 3; i++) begin
        ek = (i == 2) ? 8'h0F : 8'hFF;
        nChecks++;
        if (outBeat[i] !== {beatWord(0, 0, i), ek, i == 2}) begin
          nFails++;
          $display("FAIL single_beat%0d: got %h expected %h", i,
                   outBeat[i], {beatWord(0, 0, i), ek, i == 2});
        end
      end
    end
    nChecks++;
    if (stat0 !== (STATS ? SW'(1) : SW'(0)) || grant !== 1'b0) begin
      nFails++;
      $display("FAIL single_stat_grant: got %0d/%b expected %0d/0",
               stat0, grant, STATS);
    end
  endtask

  task automatic test_held();
    doReset();
    pushPkt(0, metaWord(0, 5), 5, 2, 8'hFF, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    nChecks++;
    if (a0DRdy !== 1'b0 || outBeat.size() != 0 || busy !== 1'b0) begin
      nFails++;
      $display("FAIL held_data: got rdy=%b beats=%0d busy=%b expected 0 0 0",
               a0DRdy, outBeat.size(), busy);
    end
    mQ0.push_back(metaWord(0, 5));
    waitBeats(2);
    nChecks++;
    if (outBeat.size() != 2 || outBeat[0].d !== beatWord(0, 5, 0)
        || outBeat[1].d !== beatWord(0, 5, 1)) begin
      nFails++;
      $display("FAIL held_release: got %0d beats expected 2 in order",
               outBeat.size());
    end
  endtask

  task automatic test_alternate();
    doReset();
    for (int p = 0; p < 4; p++) begin
      pushPkt(0, metaWord(0, p), p, 2, 8'hFF, 1'b1);
      pushPkt(1, metaWord(1, p), p, 2, 8'hFF, 1'b1);
    end
    waitBeats(16);
    nChecks++;
    if (outMeta.size() != 8 || outBeat.size() != 16) begin
      nFails++;
      $display("FAIL alt_count: got %0d/%0d expected 8/16",
               outMeta.size(), outBeat.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        nChecks++;
        if (outMeta[i] !== metaWord(i % 2, i / 2)) begin
          nFails++;
          $display("FAIL alt_meta%0d: got %h expected %h", i, outMeta[i],
                   metaWord(i % 2, i / 2));
        end
        for (int b = 0; b < 2; b++) begin
          nChecks++;
          if (outBeat[2 * i + b].d !== beatWord(i % 2, i / 2, b)) begin
            nFails++;
            $display("FAIL alt_beat%0d_%0d: got %h expected %h", i, b,
                     outBeat[2 * i + b].d, beatWord(i % 2, i / 2, b));
          end
        end
        if (i > 0) begin
          nChecks++;
          if (outMetaCyc[i] != outBeatCyc[2 * i - 1] + 2) begin
            nFails++;
            $display("FAIL alt_gap%0d: got %0d expected %0d", i,
                     outMetaCyc[i], outBeatCyc[2 * i - 1] + 2);
          end
        end
      end
    end
    nChecks++;
    if (stat0 !== (STATS ? SW'(4) : SW'(0))
        || stat1 !== (STATS ? SW'(4) : SW'(0))) begin
      nFails++;
      $display("FAIL alt_stats: got %0d/%0d expected %0d each",
               stat0, stat1, STATS ? 4 : 0);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic expR;
    doReset();
    readyToggle = 1'b1;
    pushPkt(1, metaWord(1, 9), 9, 6, 8'h3F, 1'b1);
    acc = 0;
    for (int c = 0; c < 60 && acc < 6; c++) begin
      @(negedge clk);
      #2;
      expR = (c >= 2) ? dOutRdy : 1'b0;
      nChecks++;
      if (a1DRdy !== expR || a0DRdy !== 1'b0) begin
        nFails++;
        $display("FAIL bp_ready c%0d: got %b/%b expected %b/0", c,
                 a1DRdy, a0DRdy, expR);
      end
      if (c >= 2 && dOutRdy) acc++;
    end
    readyToggle = 1'b0;
    waitBeats(6);
    nChecks++;
    if (outBeat.size() != 6) begin
      nFails++;
      $display("FAIL bp_count: got %0d expected 6", outBeat.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        nChecks++;
        if (outBeat[i].d !== beatWord(1, 9, i)) begin
          nFails++;
          $display("FAIL bp_beat%0d: got %h expected %h", i,
                   outBeat[i].d, beatWord(1, 9, i));
        end
      end
    end
  endtask

  task automatic test_enable();
    doReset();
    pushPkt(0, metaWord(0, 0), 0, 5, 8'h01, 1'b1);
    pushPkt(0, metaWord(0, 1), 1, 2, 8'hFF, 1'b1);
    for (int i = 0; i < 50 && outBeat.size() < 1; i++) begin
      @(negedge clk);
      #2;
    end
    en = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    nChecks++;
    if (outBeat.size() != 5 || outMeta.size() != 1 || busy !== 1'b0) begin
      nFails++;
      $display("FAIL en_block: got beats=%0d metas=%0d busy=%b expected 5 1 0",
               outBeat.size(), outMeta.size(), busy);
    end
    en = 1'b1;
    waitBeats(7);
    nChecks++;
    if (outMeta.size() != 2 || outBeat.size() != 7) begin
      nFails++;
      $display("FAIL en_resume: got %0d/%0d expected 2/7",
               outMeta.size(), outBeat.size());
    end else begin
      nChecks++;
      if (outMeta[1] !== metaWord(0, 1) || outBeat[4].l !== 1'b1) begin
        nFails++;
        $display("FAIL en_order: got %h expected %h", outMeta[1],
                 metaWord(0, 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    pushPkt(0, metaWord(0, 2), 2, 2, 8'hFF, 1'b1);
    pushPkt(0, metaWord(0, 3), 3, 6, 8'hFF, 1'b1);
    for (int i = 0; i < 60 && outBeat.size() < 4; i++) begin
      @(negedge clk);
      #2;
    end
    nChecks++;
    if (stat0 !== (STATS ? SW'(1) : SW'(0)) || busy !== 1'b1) begin
      nFails++;
      $display("FAIL rmid_pre: got %0d/%b expected %0d/1", stat0, busy, STATS);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    nChecks++;
    if ({mOutVld, dOutVld, busy, grant, a0DRdy, a0MetaRdy} !== 6'b0
        || stat0 !== '0) begin
      nFails++;
      $display("FAIL rmid_post: got %b%b%b%b%b%b stat=%0d expected all 0",
               mOutVld, dOutVld, busy, grant, a0DRdy, a0MetaRdy, stat0);
    end
    doReset();
    pushPkt(1, metaWord(1, 4), 4, 2, 8'hFF, 1'b1);
    waitBeats(2);
    nChecks++;
    if (outMeta.size() != 1 || outMeta[0] !== metaWord(1, 4) || grant !== 1'b1
        || stat1 !== (STATS ? SW'(1) : SW'(0))) begin
      nFails++;
      $display("FAIL rmid_after: got metas=%0d grant=%b stat1=%0d expected 1 1 %0d",
               outMeta.size(), grant, stat1, STATS);
    end
  endtask

  task automatic test_wrap();
    doReset();
    for (int p = 0; p < 17; p++) pushPkt(1, metaWord(1, p), p, 1, 8'hFF, 1'b1);
    waitBeats(17);
    nChecks++;
    if (outMeta.size() != 17 || outBeat.size() != 17) begin
      nFails++;
      $display("FAIL wrap_count: got %0d/%0d expected 17/17",
               outMeta.size(), outBeat.size());
    end
    nChecks++;
    if (stat1 !== (STATS ? SW'(1) : SW'(0)) || stat0 !== '0) begin
      nFails++;
      $display("FAIL wrap_stat: got %0d/%0d expected %0d/0", stat1, stat0,
               STATS);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_held();
    test_alternate();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
